// File: rtl/line_buffer.sv
// Purpose : two-line raster buffer presenting a vertical 3-pixel column (rows r-2, r-1, r) per input pixel.
// Latency : 1 cycle from in_valid/in_data to out_valid/out_row*; out_valid is in_valid registered.
// Backpressure: none; the source stalls by dropping in_valid, and all state including outputs holds meanwhile.
//
// Ports:
//   clk       - single clock, all state updates on its rising edge
//   rst       - synchronous active-high reset, takes priority over in_valid
//   in_valid  - in_data carries a pixel this cycle
//   in_data   - 8-bit pixel, raster order (row-major, column 0 first)
//   out_valid - row outputs were updated on the last edge
//   out_row0  - pixel two rows above the current one, same column (oldest)
//   out_row1  - pixel one row above the current one, same column
//   out_row2  - current pixel (newest)
//   out_col   - column index of the pixel on out_row2
//   out_row   - row index of the pixel on out_row2
module line_buffer #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int PADDING = 1,
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          out_valid,
    output logic [7:0]    out_row0,
    output logic [7:0]    out_row1,
    output logic [7:0]    out_row2,
    output logic [CW-1:0] out_col,
    output logic [RW-1:0] out_row
);

    // lb1 holds the previous row, lb0 the row before that. Each column slot
    // shifts lb1 -> lb0 and takes the new pixel into lb1 in the same edge that
    // its old contents are read out, so a single read port per memory suffices.
    logic [7:0] lb0 [IMG_W];
    logic [7:0] lb1 [IMG_W];

    // Position of the next pixel to arrive.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [7:0]    rd_lb0;
    logic [7:0]    rd_lb1;
    logic          last_col;
    logic          last_row;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic          mask_row1;
    logic          mask_row0;
    logic [7:0]    row1_dat;
    logic [7:0]    row0_dat;

    always_comb begin
        rd_lb0   = lb0[col];
        rd_lb1   = lb1[col];

        last_col = (col == CW'(IMG_W - 1));
        last_row = (row == RW'(IMG_H - 1));

        col_nxt  = last_col ? '0 : col + 1'b1;
        row_nxt  = row;
        if (last_col) begin
            row_nxt = last_row ? '0 : row + 1'b1;
        end

        // Rows above the frame top read as zero when padding is enabled.
        // The memories still hold the previous frame; only the outputs are
        // masked, so without padding a new frame sees the old frame's tail.
        mask_row1 = (PADDING != 0) && (row == '0);
        mask_row0 = (PADDING != 0) && ((row == '0) || (row == RW'(1)));

        row1_dat  = mask_row1 ? 8'd0 : rd_lb1;
        row0_dat  = mask_row0 ? 8'd0 : rd_lb0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_row0  <= '0;
            out_row1  <= '0;
            out_row2  <= '0;
            out_col   <= '0;
            out_row   <= '0;
            col       <= '0;
            row       <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_row2  <= in_data;
                out_row1  <= row1_dat;
                out_row0  <= row0_dat;
                out_col   <= col;
                out_row   <= row;
                lb0[col]  <= rd_lb1;
                lb1[col]  <= in_data;
                col       <= col_nxt;
                row       <= row_nxt;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Purpose : directed checks of line_buffer with a 4x3 frame, padded and unpadded instances side by side.
// Latency : outputs sampled 1 time unit after the edge that registers each input.
// Backpressure: stalls are exercised by dropping in_valid for several cycles.
module tb_line_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    logic       p_valid, n_valid;
    logic [7:0] p_r0, p_r1, p_r2, n_r0, n_r1, n_r2;
    logic [1:0] p_col, p_row, n_col, n_row;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_buffer #(.IMG_W(4), .IMG_H(3), .PADDING(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(p_valid), .out_row0(p_r0), .out_row1(p_r1), .out_row2(p_r2),
        .out_col(p_col), .out_row(p_row)
    );

    line_buffer #(.IMG_W(4), .IMG_H(3), .PADDING(0)) dut_np (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(n_valid), .out_row0(n_r0), .out_row1(n_r1), .out_row2(n_r2),
        .out_col(n_col), .out_row(n_row)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive inputs away from the rising edge, then sample just after it.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_p(input string tag, input int r2, input int r1, input int r0,
                         input int c, input int rw, input int v);
        chk({tag, ".p_r2"},  p_r2,  r2);
        chk({tag, ".p_r1"},  p_r1,  r1);
        chk({tag, ".p_r0"},  p_r0,  r0);
        chk({tag, ".p_col"}, p_col, c);
        chk({tag, ".p_row"}, p_row, rw);
        chk({tag, ".p_vld"}, p_valid, v);
    endtask

    task automatic chk_zero(input string tag);
        chk_p(tag, 0, 0, 0, 0, 0, 0);
        chk({tag, ".n_r2"},  n_r2,  0);
        chk({tag, ".n_r1"},  n_r1,  0);
        chk({tag, ".n_r0"},  n_r0,  0);
        chk({tag, ".n_col"}, n_col, 0);
        chk({tag, ".n_row"}, n_row, 0);
        chk({tag, ".n_vld"}, n_valid, 0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;

        // Reset dominates a valid 0xFF input.
        step(1'b1, 1'b1, 8'hFF);
        chk_zero("rst_c1");
        step(1'b1, 1'b1, 8'hFF);
        chk_zero("rst_c2");
        step(1'b0, 1'b0, 8'hFF);
        chk_zero("post_rst");

        // Frame 1, row 0: padding zeroes both upper rows.
        step(1'b0, 1'b1, 8'd1);
        chk_p("px1", 1, 0, 0, 0, 0, 1);
        step(1'b0, 1'b1, 8'd2);
        step(1'b0, 1'b1, 8'd3);
        step(1'b0, 1'b1, 8'd4);
        chk_p("px4", 4, 0, 0, 3, 0, 1);

        // Row 1: only the oldest row is masked.
        step(1'b0, 1'b1, 8'd11);
        chk_p("px11", 11, 1, 0, 0, 1, 1);
        chk("px11.n_r1", n_r1, 1);
        step(1'b0, 1'b1, 8'd12);
        chk_p("px12", 12, 2, 0, 1, 1, 1);

        // Three-cycle stall mid-row: outputs hold, out_valid drops.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'hAA);
            chk_p($sformatf("stall%0d", i), 12, 2, 0, 1, 1, 0);
        end
        step(1'b0, 1'b1, 8'd13);
        chk_p("px13", 13, 3, 0, 2, 1, 1);
        step(1'b0, 1'b1, 8'd14);
        chk_p("px14", 14, 4, 0, 3, 1, 1);

        // Row 2: steady state, no masking.
        step(1'b0, 1'b1, 8'd21);
        chk_p("px21", 21, 11, 1, 0, 2, 1);
        step(1'b0, 1'b1, 8'd22);
        chk_p("px22", 22, 12, 2, 1, 2, 1);
        chk("px22.n_r0", n_r0, 2);
        step(1'b0, 1'b1, 8'd23);
        step(1'b0, 1'b1, 8'd24);
        chk_p("px24", 24, 14, 4, 3, 2, 1);

        // Frame 2 first pixel: padded sees zeros, unpadded sees old frame tail.
        step(1'b0, 1'b1, 8'd101);
        chk_p("px101", 101, 0, 0, 0, 0, 1);
        chk("px101.n_r2",  n_r2, 101);
        chk("px101.n_r1",  n_r1, 21);
        chk("px101.n_r0",  n_r0, 11);
        chk("px101.n_row", n_row, 0);
        step(1'b0, 1'b1, 8'd102);
        chk("px102.n_r1", n_r1, 22);
        chk("px102.n_r0", n_r0, 12);
        step(1'b0, 1'b1, 8'd103);
        step(1'b0, 1'b1, 8'd104);
        step(1'b0, 1'b1, 8'd111);
        chk_p("px111", 111, 101, 0, 0, 1, 1);
        chk("px111.n_r0", n_r0, 21);
        step(1'b0, 1'b1, 8'd112);

        // Mid-frame reset with in_valid high: position and memories cleared.
        step(1'b1, 1'b1, 8'd77);
        chk_zero("midrst");
        step(1'b0, 1'b1, 8'd1);
        chk_p("after_rst", 1, 0, 0, 0, 0, 1);
        chk("after_rst.n_r1", n_r1, 0);
        chk("after_rst.n_r0", n_r0, 0);
        step(1'b0, 1'b1, 8'd2);
        chk("after_rst2.n_r1", n_r1, 0);
        chk("after_rst2.n_col", n_col, 1);
        step(1'b0, 1'b0, 8'd0);
        chk("idle.p_vld", p_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 Parameter IMG_W, default 28: pixels per image row; legal values are 2 or more.
REQ-002 Parameter IMG_H, default 28: rows per frame; legal values are 2 or more.
REQ-003 Parameter PADDING, default 1: 1 = rows above the frame top read as zero; 0 = no masking.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: in_data carries a valid pixel this cycle.
REQ-007 Port in_data, input, 8: pixel, raster order (row-major, column 0 first).
REQ-008 Port out_valid, output, 1: row outputs updated this cycle.
REQ-009 Port out_row0, output, 8: pixel two rows above the current pixel, same column (oldest).
REQ-010 Port out_row1, output, 8: pixel one row above the current pixel, same column.
REQ-011 Port out_row2, output, 8: current pixel (newest).
REQ-012 Port out_col, output, clog2(IMG_W) bits: column index of the pixel on out_row2.
REQ-013 Port out_row, output, clog2(IMG_H) bits: row index of the pixel on out_row2.

Function
REQ-014 The block SHALL hold two line memories, LB1 (previous row) and LB0 (row before that), each IMG_W x 8 bits.
REQ-015 Internal counters col and row SHALL give the position of the next input pixel.
REQ-016 On a cycle with in_valid=1 at column c, out_row2 SHALL take in_data, out_row1 SHALL take LB1[c], and out_row0 SHALL take LB0[c], all on the same edge.
REQ-017 On the same edge, LB0[c] SHALL take LB1[c] and LB1[c] SHALL take in_data; this is a read-before-write per column.
REQ-018 Latency from input to output SHALL be exactly 1 cycle: out_valid is in_valid registered.
REQ-019 out_col and out_row SHALL register the pre-increment col and row values on that same edge.
REQ-020 col SHALL increment per valid pixel and wrap from IMG_W-1 to 0. When col wraps, row SHALL increment, and row SHALL wrap from IMG_H-1 to 0; that wrap starts a new frame.
REQ-021 With PADDING=1 and row=0, out_row1 and out_row0 SHALL be forced to 0.
REQ-022 With PADDING=1 and row=1, out_row0 SHALL be forced to 0.
REQ-023 Line-memory writes SHALL still occur normally under forcing; only the outputs are masked.
REQ-024 With PADDING=0, no masking SHALL occur. Across a frame wrap, out_row1 and out_row0 SHALL then return the previous frame's last rows.
REQ-025 On a cycle with in_valid=0: out_valid SHALL be 0; out_row0/1/2, out_col and out_row SHALL hold; counters and memories SHALL hold.
REQ-026 Stalls of any length, including mid-row, SHALL NOT change the pixel sequence; the next valid pixel continues at the next column.
REQ-027 Output data SHALL be treated as unsigned 8-bit pass-through with no arithmetic; signedness is the consumer's concern.

Reset
REQ-028 While rst=1 at a clock edge, all of the following SHALL be 0: out_valid, out_row0, out_row1, out_row2, out_col, out_row, col, row, and every LB0/LB1 entry.
REQ-029 rst SHALL take priority over in_valid.
REQ-030 Reset asserted mid-frame SHALL discard position. The first valid pixel after reset is row 0, column 0.

Verification
REQ-031 Reset check: assert rst for 2 cycles with in_valid=1 and in_data=0xFF. Required: every output is 0 during reset and on the first cycle after it.
REQ-032 Steady state (IMG_W=4, IMG_H=3, PADDING=1; pixel = 10*row + col + 1, streamed continuously): input 22 (row 2, col 1). Required next cycle: out_row2=22, out_row1=12, out_row0=2, out_col=1, out_row=2, out_valid=1.
REQ-033 Top padding, same setup:
  - input 4 (row 0, col 3) -> out_row2=4, out_row1=0, out_row0=0.
  - input 11 (row 1, col 0) -> out_row2=11, out_row1=1, out_row0=0.
REQ-034 Frame wrap, same setup: second frame, first pixel 101.
  - PADDING=1 -> out_row2=101, out_row1=0, out_row0=0, out_row=0.
  - PADDING=0 -> out_row1=21, out_row0=11.
REQ-035 Stall: drop in_valid for 3 cycles after input 12 (row 1, col 1), then send 13. Required:
  - during the stall, out_valid=0 and outputs hold 12/2/0;
  - then out_row2=13, out_row1=3, out_col=2.
REQ-036 Mid-frame reset: pulse rst after input 12, then send 1. Required: out_row=0, out_col=0, out_row1=0, out_row0=0.
